// File: rtl/ard_frame_rx.sv
// Oversampling serial receiver: start bit, FRAME_BITS data bits LSB-first, even parity, stop bit.
// Presents a parallel frame only when start, parity and stop are all good.
module ard_frame_rx #(
    parameter int FRAME_BITS = 48,
    parameter int BIT_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dataIn,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frameValid,
    output logic                  frameError,
    output logic                  busy
);

    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] HALF_LAST = TW'(BIT_PERIOD / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(BIT_PERIOD - 1);
    localparam logic [5:0]    LAST_BIT  = 6'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                  stateReg;
    logic                    syncMeta;
    logic                    s;
    logic                    sD;
    logic [TW-1:0]           bitTimerReg;
    logic [5:0]              bitCountReg;
    logic [FRAME_BITS-1:0]   shiftReg;
    logic                    parityBadReg;

    // Synchronizer and edge-detect history idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncMeta <= 1'b1;
            s        <= 1'b1;
            sD       <= 1'b1;
        end else begin
            syncMeta <= dataIn;
            s        <= syncMeta;
            sD       <= s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg     <= IDLE;
            bitTimerReg  <= '0;
            bitCountReg  <= '0;
            shiftReg     <= '0;
            parityBadReg <= 1'b0;
            frame        <= '0;
            frameValid   <= 1'b0;
            frameError   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frameValid  <= 1'b0;
            frameError  <= 1'b0;
            bitTimerReg <= (bitTimerReg == FULL_LAST) ? '0 : bitTimerReg + TIMER_ONE;

            case (stateReg)
                IDLE: begin
                    bitTimerReg <= '0;
                    bitCountReg <= '0;
                    if (sD && !s) begin
                        stateReg <= START;
                        busy     <= 1'b1;
                    end
                end

                // Half a bit after the falling edge lands in the start-bit centre.
                START: begin
                    if (bitTimerReg == HALF_LAST) begin
                        bitTimerReg <= '0;
                        bitCountReg <= '0;
                        if (s) begin
                            stateReg <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            stateReg <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (bitTimerReg == FULL_LAST) begin
                        shiftReg <= {s, shiftReg[FRAME_BITS-1:1]};
                        if (bitCountReg == LAST_BIT) begin
                            stateReg    <= PARITY;
                            bitCountReg <= '0;
                        end else begin
                            bitCountReg <= bitCountReg + 6'd1;
                        end
                    end
                end

                PARITY: begin
                    if (bitTimerReg == FULL_LAST) begin
                        parityBadReg <= (^shiftReg) ^ s;
                        stateReg     <= STOP;
                    end
                end

                STOP: begin
                    if (bitTimerReg == FULL_LAST) begin
                        if (s) begin
                            stateReg <= IDLE;
                            busy     <= 1'b0;
                            if (parityBadReg) begin
                                frameError <= 1'b1;
                            end else begin
                                frame      <= shiftReg;
                                frameValid <= 1'b1;
                            end
                        end else begin
                            frameError <= 1'b1;
                            stateReg   <= WAIT_IDLE;
                        end
                    end
                end

                // A line stuck low after a framing error must rise before we rearm.
                WAIT_IDLE: begin
                    bitTimerReg <= '0;
                    if (s) begin
                        stateReg <= IDLE;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    stateReg <= IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ard_frame_rx.sv
// Randomized bench for ard_frame_rx: drives serial frames and checks each pulse against a frame-level model.
module tb_ard_frame_rx;

    localparam int FB  = 48;
    localparam int BP  = 4;
    // Start edge driven at cycle N is detected at N+3; the stop sample lands BP/2+(FB+2)*BP later.
    localparam int LAT = 3 + BP / 2 + (FB + 2) * BP;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dataIn = 1'b1;
    logic [FB-1:0] frame;
    logic          frameValid;
    logic          frameError;
    logic          busy;

    ard_frame_rx #(.FRAME_BITS(FB), .BIT_PERIOD(BP)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .frame     (frame),
        .frameValid(frameValid),
        .frameError(frameError),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            cyc;
        bit            good;
        logic [FB-1:0] frame;
    } exp_t;

    exp_t          expQ[$];
    logic [FB-1:0] modelFrame = '0;
    bit            monitorOn = 1'b0;
    int            txn = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (monitorOn && (frameValid || frameError)) begin
            check("exclusive", 64'(frameValid & frameError), 64'd0);
            if (expQ.size() == 0) begin
                check("unexpected pulse", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                check("pulse cycle", 64'(cyc), 64'(e.cyc));
                check("frameValid", 64'(frameValid), 64'(e.good));
                check("frameError", 64'(frameError), 64'(!e.good));
                check("frame", 64'(frame), 64'(e.frame));
                $display("txn %0d: cycle %0d valid=%0b error=%0b frame=%012h", txn, cyc,
                         frameValid, frameError, frame);
                txn++;
            end
        end
    end

    task automatic sendBit(input logic b);
        dataIn = b;
        repeat (BP) @(negedge clk);
    endtask

    // Frame-level model: accepted iff stop is 1 and parity bit equals XOR of the data.
    task automatic sendFrame(input logic [FB-1:0] data, input logic parityBit,
                             input logic stopBit, input int holdLow);
        exp_t e;
        e.cyc  = cyc + LAT;
        e.good = stopBit && (parityBit == (^data));
        if (e.good) modelFrame = data;
        e.frame = modelFrame;
        expQ.push_back(e);
        sendBit(1'b0);
        for (int i = 0; i < FB; i++) sendBit(data[i]);
        sendBit(parityBit);
        sendBit(stopBit);
        if (!stopBit) begin
            repeat (holdLow) @(negedge clk);
            check("busy while low", 64'(busy), 64'd1);
            dataIn = 1'b1;
            repeat (2) @(negedge clk);
            check("busy before rise seen", 64'(busy), 64'd1);
            @(negedge clk);
            check("busy after rise", 64'(busy), 64'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
        check("pending pulses", 64'(expQ.size()), 64'd0);
    endtask

    function automatic logic [FB-1:0] randFrame();
        return {$urandom(), $urandom()};
    endfunction

    initial begin : main
        logic [FB-1:0] d;
        repeat (3) @(negedge clk);
        check("reset frame", 64'(frame), 64'd0);
        check("reset frameValid", 64'(frameValid), 64'd0);
        check("reset frameError", 64'(frameError), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        monitorOn = 1'b1;
        check("idle busy", 64'(busy), 64'd0);

        d = 48'h0000_0009_0400;
        sendFrame(d, ^d, 1'b1, 0);
        sendFrame(48'h0000_0000_0001, 1'b0, 1'b1, 0);
        d = randFrame();
        sendFrame(d, ^d, 1'b0, 40);

        // One-clock glitch: detected, rejected at the start-bit centre, no pulse.
        repeat (3) @(negedge clk);
        dataIn = 1'b0;
        @(negedge clk);
        dataIn = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        check("glitch idle", 64'(busy), 64'd0);
        d = randFrame();
        sendFrame(d, ^d, 1'b1, 0);

        sendFrame(48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 0);
        sendFrame(48'h0, 1'b0, 1'b1, 0);
        d = randFrame() | 48'h1;
        sendFrame(d, ^d, 1'b1, 0);
        drain();
        check("frame before reset", 64'(frame), 64'(modelFrame));

        // Reset in the middle of data bit 20.
        sendBit(1'b0);
        for (int i = 0; i < 20; i++) sendBit(1'($urandom()));
        dataIn = 1'($urandom());
        repeat (BP / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset frame", 64'(frame), 64'd0);
        check("midreset frameValid", 64'(frameValid), 64'd0);
        check("midreset frameError", 64'(frameError), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        modelFrame = '0;
        dataIn = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        d = randFrame();
        sendFrame(d, ^d, 1'b1, 0);

        for (int n = 0; n < 12; n++) begin
            logic p;
            logic stopB;
            d     = randFrame();
            p     = ($urandom_range(0, 3) == 0) ? !(^d) : ^d;
            stopB = ($urandom_range(0, 4) != 0);
            sendFrame(d, p, stopB, $urandom_range(2, 20));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
